uc_secuencial: RTL and testbench

UC_SECUENCIAL -- requirements
Module: uc_secuencial

---
 rtl/uc_secuencial.sv | 202 ++++++++++++++++++++
 tb/tb_uc_secuencial.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uc_secuencial.sv
// uc_secuencial: sequential control unit for a small accumulator-style CPU.
// Decodes instruction[31:24] into datapath controls, sequences I/O accesses
// with a bounded wait, and handles eight prioritised interrupt lines with a
// single in-service level.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset; forces every output to 0
//   opcode     instruction[31:24]
//   z, c       datapath flags
//   int_pend   pending interrupt lines, bit 0 highest priority
//   io_ack     peripheral completion for the current I/O access
//   pc_en, s_rel_pc, s_inm, s_pila, s_datos, we3, wez, push, pop, oe,
//   s_inc, op_alu                 datapath controls
//   s_calli, s_reti               one-hot interrupt call/return strobes
//   io_req, io_we                 I/O request and direction (1 = write)
//   halted, bus_err, illegal      status (bus_err, illegal sticky)
module uc_secuencial #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] opcode,
  input  logic       z,
  input  logic       c,
  input  logic [7:0] int_pend,
  input  logic       io_ack,
  output logic       pc_en,
  output logic       s_rel_pc,
  output logic       s_inm,
  output logic       s_pila,
  output logic       s_datos,
  output logic       we3,
  output logic       wez,
  output logic       push,
  output logic       pop,
  output logic       oe,
  output logic [1:0] s_inc,
  output logic [2:0] op_alu,
  output logic [7:0] s_calli,
  output logic [7:0] s_reti,
  output logic       io_req,
  output logic       io_we,
  output logic       halted,
  output logic       bus_err,
  output logic       illegal
);

  typedef enum logic [1:0] {RUN, IO_WAIT, HALT} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_isr, w_isr_nxt;
  logic       r_in_isr, w_in_isr_nxt;
  logic       r_io_we, w_io_we_nxt;
  logic       r_bus_err, w_bus_err_nxt;
  logic       r_illegal, w_illegal_nxt;
  logic [7:0] w_lowest;
  logic       w_accept;
  logic       w_timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= RUN;
      r_cnt     <= '0;
      r_isr     <= '0;
      r_in_isr  <= 1'b0;
      r_io_we   <= 1'b0;
      r_bus_err <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_isr     <= w_isr_nxt;
      r_in_isr  <= w_in_isr_nxt;
      r_io_we   <= w_io_we_nxt;
      r_bus_err <= w_bus_err_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  always_comb begin
    pc_en    = 1'b0;
    s_rel_pc = 1'b0;
    s_inm    = 1'b0;
    s_pila   = 1'b0;
    s_datos  = 1'b0;
    we3      = 1'b0;
    wez      = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    oe       = 1'b0;
    s_inc    = 2'b00;
    op_alu   = 3'b000;
    s_calli  = '0;
    s_reti   = '0;
    io_req   = 1'b0;
    io_we    = 1'b0;
    halted   = 1'b0;
    bus_err  = 1'b0;
    illegal  = 1'b0;

    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_isr_nxt     = r_isr;
    w_in_isr_nxt  = r_in_isr;
    w_io_we_nxt   = r_io_we;
    w_bus_err_nxt = r_bus_err;
    w_illegal_nxt = r_illegal;

    // Isolate the lowest set pending line (two's-complement trick).
    w_lowest  = int_pend & (~int_pend + 8'd1);
    w_accept  = (r_state != IO_WAIT) && !r_in_isr && (int_pend != '0);
    // r_cnt holds completed wait cycles, so the current cycle is r_cnt+1.
    w_timeout = (r_cnt == 8'(TIMEOUT - 1));

    // Outputs are gated by reset so they drop without waiting for a clock.
    if (reset) begin
      halted  = (r_state == HALT);
      bus_err = r_bus_err;
      illegal = r_illegal;

      if (w_accept) begin
        push         = 1'b1;
        s_inc        = 2'b10;
        pc_en        = 1'b1;
        s_calli      = w_lowest;
        w_isr_nxt    = w_lowest;
        w_in_isr_nxt = 1'b1;
        w_state_nxt  = RUN;
      end else begin
        case (r_state)
          IO_WAIT: begin
            io_req    = 1'b1;
            io_we     = r_io_we;
            oe        = r_io_we;
            w_cnt_nxt = r_cnt + 8'd1;
            if (io_ack) begin
              pc_en       = 1'b1;
              s_datos     = !r_io_we;
              we3         = !r_io_we;
              w_state_nxt = RUN;
            end else if (w_timeout) begin
              pc_en         = 1'b1;
              w_bus_err_nxt = 1'b1;
              w_state_nxt   = RUN;
            end
          end
          HALT: ;
          default: begin
            pc_en = 1'b1;
            if (opcode[7:3] == 5'b00000) begin
              op_alu = opcode[2:0];
              we3    = 1'b1;
              wez    = 1'b1;
            end else if (opcode[7:3] == 5'b00010) begin
              op_alu = opcode[2:0];
              we3    = 1'b1;
              wez    = 1'b1;
              s_inm  = 1'b1;
            end else begin
              case (opcode)
                8'h20, 8'h21: begin
                  pc_en       = 1'b0;
                  w_cnt_nxt   = '0;
                  w_io_we_nxt = opcode[0];
                  w_state_nxt = IO_WAIT;
                end
                8'h30: s_inc = 2'b01;
                8'h31: s_rel_pc = z;
                8'h32: s_rel_pc = !z;
                8'h33: s_rel_pc = c;
                8'h40: begin
                  push  = 1'b1;
                  s_inc = 2'b01;
                end
                8'h41: begin
                  pop    = 1'b1;
                  s_pila = 1'b1;
                end
                8'h50: begin
                  pop    = 1'b1;
                  s_pila = 1'b1;
                  if (r_in_isr) begin
                    s_reti       = r_isr;
                    w_in_isr_nxt = 1'b0;
                  end else begin
                    w_illegal_nxt = 1'b1;
                  end
                end
                8'h60:   w_state_nxt = HALT;
                8'hFF:   ;
                default: w_illegal_nxt = 1'b1;
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uc_secuencial.sv
module tb_uc_secuencial;

  localparam int unsigned TO = 4;

  logic       clk;
  logic       reset;
  logic [7:0] opcode;
  logic       z, c;
  logic [7:0] int_pend;
  logic       io_ack;
  logic       pc_en, s_rel_pc, s_inm, s_pila, s_datos, we3, wez, push, pop, oe;
  logic [1:0] s_inc;
  logic [2:0] op_alu;
  logic [7:0] s_calli, s_reti;
  logic       io_req, io_we, halted, bus_err, illegal;

  uc_secuencial #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .c(c),
    .int_pend(int_pend), .io_ack(io_ack),
    .pc_en(pc_en), .s_rel_pc(s_rel_pc), .s_inm(s_inm), .s_pila(s_pila),
    .s_datos(s_datos), .we3(we3), .wez(wez), .push(push), .pop(pop), .oe(oe),
    .s_inc(s_inc), .op_alu(op_alu), .s_calli(s_calli), .s_reti(s_reti),
    .io_req(io_req), .io_we(io_we), .halted(halted), .bus_err(bus_err),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: mode 0 = running, 1 = waiting on I/O, 2 = halted.
  int         m_mode, n_mode;
  int         m_waited, n_waited;
  bit         m_wr, n_wr;
  bit         m_busy, n_busy;
  bit [7:0]   m_line, n_line;
  bit         m_be, n_be;
  bit         m_il, n_il;

  task automatic model_reset();
    m_mode = 0; m_waited = 0; m_wr = 0; m_busy = 0; m_line = 0; m_be = 0; m_il = 0;
  endtask

  task automatic model_eval(output logic [35:0] e);
    bit pc, rel, inm, pila, datos, w3, wz, ps, pp, o, rq, wr, hl;
    bit [1:0] inc;
    bit [2:0] alu;
    bit [7:0] calli, reti;
    int k;
    {pc, rel, inm, pila, datos, w3, wz, ps, pp, o, rq, wr, hl} = '0;
    inc = 0; alu = 0; calli = 0; reti = 0;
    n_mode = m_mode; n_waited = m_waited; n_wr = m_wr; n_busy = m_busy;
    n_line = m_line; n_be = m_be; n_il = m_il;
    if (!reset) begin
      e = '0;
      n_mode = 0; n_waited = 0; n_wr = 0; n_busy = 0; n_line = 0; n_be = 0; n_il = 0;
      return;
    end
    hl = (m_mode == 2);
    if (m_mode != 1 && !m_busy && int_pend != 0) begin
      for (int i = 7; i >= 0; i--) if (int_pend[i]) calli = 8'(1 << i);
      ps = 1; inc = 2; pc = 1;
      n_line = calli; n_busy = 1; n_mode = 0;
    end else if (m_mode == 1) begin
      rq = 1; wr = m_wr; o = m_wr;
      k = m_waited + 1;
      n_waited = k;
      if (io_ack) begin
        pc = 1; datos = !m_wr; w3 = !m_wr; n_mode = 0;
      end else if (k == TO) begin
        pc = 1; n_be = 1; n_mode = 0;
      end
    end else if (m_mode == 0) begin
      pc = 1;
      if (opcode < 8) begin
        alu = opcode[2:0]; w3 = 1; wz = 1;
      end else if (opcode >= 8'h10 && opcode < 8'h18) begin
        alu = opcode[2:0]; w3 = 1; wz = 1; inm = 1;
      end else if (opcode == 8'h20 || opcode == 8'h21) begin
        pc = 0; n_mode = 1; n_waited = 0; n_wr = (opcode == 8'h21);
      end else if (opcode == 8'h30) inc = 1;
      else if (opcode == 8'h31) rel = z;
      else if (opcode == 8'h32) rel = !z;
      else if (opcode == 8'h33) rel = c;
      else if (opcode == 8'h40) begin ps = 1; inc = 1; end
      else if (opcode == 8'h41) begin pp = 1; pila = 1; end
      else if (opcode == 8'h50) begin
        pp = 1; pila = 1;
        if (m_busy) begin reti = m_line; n_busy = 0; end
        else n_il = 1;
      end
      else if (opcode == 8'h60) n_mode = 2;
      else if (opcode != 8'hFF) n_il = 1;
    end
    e = {pc, rel, inm, pila, datos, w3, wz, ps, pp, o, inc, alu, calli, reti,
         rq, wr, hl, m_be, m_il};
  endtask

  function automatic logic [35:0] observed();
    return {pc_en, s_rel_pc, s_inm, s_pila, s_datos, we3, wez, push, pop, oe,
            s_inc, op_alu, s_calli, s_reti, io_req, io_we, halted, bus_err, illegal};
  endfunction

  task automatic step(input logic [7:0] op, input logic zz, input logic cc,
                      input logic [7:0] ip, input logic ack, input logic rst);
    logic [35:0] e;
    @(negedge clk);
    opcode = op; z = zz; c = cc; int_pend = ip; io_ack = ack; reset = rst;
    #1;
    model_eval(e);
    chk("outputs", observed(), e);
    m_mode = n_mode; m_waited = n_waited; m_wr = n_wr; m_busy = n_busy;
    m_line = n_line; m_be = n_be; m_il = n_il;
  endtask

  logic [7:0] pool [13] = '{8'h20, 8'h21, 8'h30, 8'h31, 8'h32, 8'h33, 8'h40,
                             8'h41, 8'h50, 8'h60, 8'hFF, 8'h00, 8'h10};

  task automatic rand_step(input bit allow_bad);
    logic [7:0] op, ip;
    int p;
    p = $urandom_range(0, 99);
    if (allow_bad && p < 8) op = 8'($urandom);
    else begin
      op = pool[$urandom_range(0, 12)];
      if (op == 8'h00 || op == 8'h10) op = op | 8'($urandom_range(0, 7));
    end
    ip = ($urandom_range(0, 99) < 12) ? 8'($urandom) : 8'h00;
    step(op, 1'($urandom), 1'($urandom), ip,
         ($urandom_range(0, 3) == 0), !(m_mode == 1 && $urandom_range(0, 49) == 0));
  endtask

  initial begin
    reset = 1'b0; opcode = '0; z = 0; c = 0; int_pend = '0; io_ack = 0;
    model_reset();

    // reset state and first decode
    step(8'h02, 0, 0, 8'h00, 0, 0);
    chk("rst_pc_en", 36'(pc_en), 36'd0);
    step(8'h02, 0, 0, 8'h00, 0, 1);
    chk("alu_reg", 36'({op_alu, we3, wez, pc_en, s_inc}), 36'({3'b010, 1'b1, 1'b1, 1'b1, 2'b00}));

    // conditional branch both ways
    step(8'h31, 1, 0, 8'h00, 0, 1);
    chk("jz_taken", 36'({s_rel_pc, pc_en}), 36'(2'b11));
    step(8'h31, 0, 0, 8'h00, 0, 1);
    chk("jz_not", 36'({s_rel_pc, pc_en}), 36'(2'b01));

    // IN acknowledged on the third wait cycle
    step(8'h20, 0, 0, 8'h00, 0, 1);
    step(8'hFF, 0, 0, 8'h00, 0, 1);
    chk("in_w1", 36'({io_req, pc_en}), 36'(2'b10));
    step(8'hFF, 0, 0, 8'h00, 0, 1);
    chk("in_w2", 36'({io_req, pc_en}), 36'(2'b10));
    step(8'hFF, 0, 0, 8'h00, 1, 1);
    chk("in_ack", 36'({io_req, s_datos, we3, pc_en}), 36'(4'b1111));

    // OUT timing out after TO wait cycles
    step(8'h21, 0, 0, 8'h00, 0, 1);
    for (int i = 1; i <= int'(TO); i++) begin
      step(8'hFF, 0, 0, 8'h00, 0, 1);
      chk("out_wait", 36'({io_req, io_we, oe, pc_en}), 36'({3'b111, (i == int'(TO))}));
    end
    step(8'hFF, 0, 0, 8'h00, 0, 1);
    chk("out_buserr", 36'({bus_err, pc_en, io_req}), 36'(3'b110));

    // HALT, interrupt acceptance, RETI, no re-entry while in service
    step(8'h00, 0, 0, 8'h00, 0, 0);
    step(8'h60, 0, 0, 8'h00, 0, 1);
    step(8'hFF, 0, 0, 8'h00, 0, 1);
    chk("halted", 36'({halted, pc_en}), 36'(2'b10));
    step(8'hFF, 0, 0, 8'h06, 0, 1);
    chk("accept", 36'({s_calli, push, s_inc}), 36'({8'h02, 1'b1, 2'b10}));
    step(8'hFF, 0, 0, 8'h06, 0, 1);
    chk("no_reenter", 36'({s_calli, push}), 36'd0);
    step(8'h50, 0, 0, 8'h06, 0, 1);
    chk("reti", 36'({s_reti, pop, illegal}), 36'({8'h02, 1'b1, 1'b0}));
    step(8'hFF, 0, 0, 8'h06, 0, 1);
    chk("reaccept", 36'(s_calli), 36'(8'h02));
    step(8'h50, 0, 0, 8'h00, 0, 1);
    step(8'h50, 0, 0, 8'h00, 0, 1);
    chk("reti_idle", 36'({s_reti, pop}), 36'({8'h00, 1'b1}));
    step(8'hFF, 0, 0, 8'h00, 0, 1);
    chk("reti_illegal", 36'(illegal), 36'd1);

    // reset in the middle of an I/O wait
    step(8'h21, 0, 0, 8'h00, 0, 1);
    step(8'hFF, 0, 0, 8'h00, 0, 1);
    step(8'hFF, 0, 0, 8'h00, 0, 0);
    chk("rst_io", 36'({io_req, oe, pc_en, bus_err}), 36'd0);

    // randomized episodes against the model
    for (int ep = 0; ep < 24; ep++) begin
      step(8'hFF, 0, 0, 8'h00, 0, 0);
      for (int i = 0; i < 200; i++) rand_step(ep % 3 == 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
